muldiv: RTL and testbench
=========================

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand and result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock (single clock domain).
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  unit able to accept a request.
REQ-006 SHALL have port op  input  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
REQ-007 SHALL have port a  input  WIDTH  multiplicand/dividend.
REQ-008 SHALL have port b  input  WIDTH  multiplier/divisor.
REQ-009 SHALL have port hi  output  WIDTH  product upper half / remainder.
REQ-010 SHALL have port lo  output  WIDTH  product lower half / quotient.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port div_zero  output  1  last completed divide had b==0.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-014 SHALL assert req_ready only in IDLE; handshake occurs on a rising edge with req_valid && req_ready.
REQ-015 SHALL register op, a, b on handshake and move IDLE->RUN with iteration counter loaded to WIDTH-1.
REQ-016 SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per RUN cycle, exactly WIDTH RUN cycles.
REQ-017 SHALL move RUN->FIX when counter==0; FIX applies sign correction and writes hi/lo/div_zero in one cycle.
REQ-018 SHALL move FIX->DONE, assert done for exactly the DONE cycle, then move DONE->IDLE.
REQ-019 SHALL give latency: done high in the cycle following edge WIDTH+2 after the handshake edge (18 for WIDTH=16); next handshake earliest the cycle after done.
REQ-020 SHALL ignore req_valid, op, a, b outside IDLE; held req_valid is accepted on the first IDLE edge.
REQ-021 SHALL hold hi, lo, div_zero stable from FIX until the next FIX.
REQ-022 SHALL produce the full 2*WIDTH-bit product as {hi,lo} for multiplies.
REQ-023 SHALL produce quotient in lo, remainder in hi for divides; signed divide truncates toward zero, remainder takes dividend's sign.
REQ-024 SHALL, for b==0 divides, run full latency and return lo = all ones, hi = a, div_zero = 1; any other completed op clears div_zero.
REQ-025 SHALL return lo = 0x8000 (most-negative), hi = 0, div_zero = 0 for signed most-negative / -1.

Reset
REQ-026 SHALL, on rst asserted, immediately force state IDLE, hi = 0, lo = 0, done = 0, div_zero = 0, counter = 0.
REQ-027 SHALL abort any in-flight operation on reset with no done pulse; req_ready = 1 from first edge after rst deasserts.

Configuration
REQ-028 SHALL, with MULDIV_SIGNED_EN defined, execute MULT/DIV as two's-complement signed via magnitude conversion and FIX-stage negation.
REQ-029 SHALL, without MULDIV_SIGNED_EN, ignore op[1] (MULT = MULTU, DIV = DIVU) and omit the sign logic; latency unchanged.

Structure
REQ-030 SHALL place op encodings and the FSM state typedef in shared package muldiv_pkg.
REQ-031 SHALL be a single module with no sub-modules; datapath and FSM together.

Verification
REQ-032 MULTU a=23485, b=10234 -> hi=0x0E53, lo=0x6192, done 18 cycles after handshake.
REQ-033 DIVU a=23485, b=10234 -> lo=0x0002, hi=0x0BC9, div_zero=0.
REQ-034 DIVU a=0x1234, b=0 -> lo=0xFFFF, hi=0x1234, div_zero=1; following MULTU 2*3 -> lo=6, div_zero=0.
REQ-035 MULDIV_SIGNED_EN: MULT -3*5 -> hi=0xFFFF, lo=0xFFF1; DIV -7/2 -> lo=0xFFFD, hi=0xFFFF; DIV 0x8000/0xFFFF -> lo=0x8000, hi=0.
REQ-036 rst pulsed 5 cycles into a MULTU -> no done, hi=lo=0, req_ready=1 after reset; new request completes normally.
REQ-037 req_valid held high across two requests -> second accepted exactly one cycle after first done, no request lost or duplicated.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings and the controller state type.
package muldiv_pkg;

  // Operation encodings on the op port.
  typedef enum logic [1:0] {
    OpMultu = 2'b00,
    OpDivu  = 2'b01,
    OpMult  = 2'b10,
    OpDiv   = 2'b11
  } op_e;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } state_e;

  // True for either divide encoding.
  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OpDivu) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative multiply/divide unit. One shift-add (multiply) or one
// restoring-subtract (divide) step per RUN cycle, WIDTH RUN cycles, then a
// FIX cycle that applies sign correction and updates hi/lo/div_zero, then a
// single DONE cycle carrying the done pulse.
// Optional feature: define MULDIV_SIGNED_EN to execute MULT/DIV as signed
// two's-complement operations; otherwise op[1] is ignored.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic                 is_div_q;
  logic                 b_zero_q;
  // acc_hi_q carries one extra bit for the restoring-divide partial remainder.
  logic [WIDTH:0]       acc_hi_q;
  logic [WIDTH-1:0]     acc_lo_q;
  // Multiplicand (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]     opnd_q;
  // Raw dividend, returned as the remainder of a divide by zero.
  logic [WIDTH-1:0]     a_raw_q;
`ifdef MULDIV_SIGNED_EN
  logic                 neg_lo_q;  // negate product, or quotient
  logic                 neg_hi_q;  // negate remainder
`endif

  logic                 in_div;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
`ifdef MULDIV_SIGNED_EN
  logic                 in_signed;
  logic                 a_neg;
  logic                 b_neg;
`endif

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [WIDTH:0]       step_hi;
  logic [WIDTH-1:0]     step_lo;

  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;
  logic                 fix_dz;

  assign req_ready = (state_q == StIdle);

  // Request decode: operation kind and operand magnitudes.
  always_comb begin
    in_div = op_is_div(op);
`ifdef MULDIV_SIGNED_EN
    in_signed = (op == OpMult) || (op == OpDiv);
    a_neg     = in_signed && a[WIDTH-1];
    b_neg     = in_signed && b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
`else
    a_mag = a;
    b_mag = b;
`endif
  end

  // One iteration step for multiply (shift-add) and divide (restoring).
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q[WIDTH-1:0]} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift;
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = {1'b0, mul_sum[WIDTH:1]};
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Result formation for the FIX cycle, including sign correction.
  always_comb begin
    prod = {acc_hi_q[WIDTH-1:0], acc_lo_q};
`ifdef MULDIV_SIGNED_EN
    prod_fix = neg_lo_q ? -prod : prod;
    quo_fix  = neg_lo_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = neg_hi_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
`else
    prod_fix = prod;
    quo_fix  = acc_lo_q;
    rem_fix  = acc_hi_q[WIDTH-1:0];
`endif
    if (!is_div_q) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
      fix_dz = 1'b0;
    end else if (b_zero_q) begin
      fix_hi = a_raw_q;
      fix_lo = '1;
      fix_dz = 1'b1;
    end else begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
      fix_dz = 1'b0;
    end
  end

  // Controller and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            is_div_q <= in_div;
            b_zero_q <= (b == '0);
            a_raw_q  <= a;
            acc_hi_q <= '0;
            // Multiply shifts the multiplier out of acc_lo; divide shifts
            // the dividend out of it while the quotient shifts in.
            acc_lo_q <= in_div ? a_mag : b_mag;
            opnd_q   <= in_div ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
`endif
            cnt_q    <= CntW'(WIDTH - 1);
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          hi       <= fix_hi;
          lo       <= fix_lo;
          div_zero <= fix_dz;
          done     <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv (WIDTH = 16).
// Signed vectors are used when MULDIV_SIGNED_EN is defined; otherwise the
// same op codes are checked to behave as their unsigned counterparts.
module tb_muldiv;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        done;
  logic        div_zero;

  int n_checks = 0;
  int n_pass   = 0;
  int done_count = 0;
  int hs_count   = 0;

  muldiv #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .hi        (hi),
    .lo        (lo),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_count++;
  always @(posedge clk) if (!rst && req_valid && req_ready) hs_count++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one request and count negedges from the handshake to done.
  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        output int lat);
    lat = 0;
    @(negedge clk);
    check_eq("ready_before", req_ready, 1);
    op = o; a = x; b = y; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Garbage while busy must be ignored.
    req_valid = 1'b0; op = 2'b01; a = 16'hFFFF; b = 16'h0000;
    for (int i = 2; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
  endtask

  task automatic do_vec(input string tag, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] e_hi, input logic [15:0] e_lo,
                        input logic e_dz);
    int lat;
    run_op(o, x, y, lat);
    check_eq({tag, "_latency"}, lat, 18);
    check_eq({tag, "_hi"}, hi, e_hi);
    check_eq({tag, "_lo"}, lo, e_lo);
    check_eq({tag, "_div_zero"}, div_zero, e_dz);
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, done, 0);
    check_eq({tag, "_ready_after"}, req_ready, 1);
    check_eq({tag, "_hi_hold"}, hi, e_hi);
  endtask

  initial begin
    int n_done;
    int n_hs;
    int t_done1;
    int t;
    rst = 1'b1; req_valid = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_hi", hi, 0);
    check_eq("reset_lo", lo, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_div_zero", div_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ready", req_ready, 1);

    do_vec("multu_basic", 2'b00, 16'd23485, 16'd10234, 16'h0E53, 16'h6192, 1'b0);
    do_vec("divu_basic",  2'b01, 16'd23485, 16'd10234, 16'h0BC9, 16'h0002, 1'b0);
    do_vec("divu_zero",   2'b01, 16'h1234,  16'h0000,  16'h1234, 16'hFFFF, 1'b1);
    do_vec("multu_small", 2'b00, 16'd2,     16'd3,     16'h0000, 16'h0006, 1'b0);
    do_vec("multu_max",   2'b00, 16'hFFFF,  16'hFFFF,  16'hFFFE, 16'h0001, 1'b0);
    do_vec("divu_small",  2'b01, 16'd5,     16'd7,     16'h0005, 16'h0000, 1'b0);
    do_vec("divu_by1",    2'b01, 16'hFFFF,  16'h0001,  16'h0000, 16'hFFFF, 1'b0);
`ifdef MULDIV_SIGNED_EN
    do_vec("mult_neg",    2'b10, 16'hFFFD,  16'd5,     16'hFFFF, 16'hFFF1, 1'b0);
    do_vec("div_neg",     2'b11, 16'hFFF9,  16'd2,     16'hFFFF, 16'hFFFD, 1'b0);
    do_vec("div_ovf",     2'b11, 16'h8000,  16'hFFFF,  16'h0000, 16'h8000, 1'b0);
    do_vec("div_zero_s",  2'b11, 16'hFFF9,  16'h0000,  16'hFFF9, 16'hFFFF, 1'b1);
`else
    do_vec("mult_as_u",   2'b10, 16'hFFFD,  16'd5,     16'h0004, 16'hFFF1, 1'b0);
    do_vec("div_as_u",    2'b11, 16'hFFF9,  16'd2,     16'h0001, 16'h7FFC, 1'b0);
`endif

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = 2'b00; a = 16'd100; b = 16'd200; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_done = done_count;
    rst = 1'b1;
    #1;
    check_eq("abort_hi", hi, 0);
    check_eq("abort_lo", lo, 0);
    check_eq("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("abort_no_done", done_count, n_done);
    check_eq("abort_ready", req_ready, 1);
    check_eq("abort_lo_after", lo, 0);
    do_vec("after_abort", 2'b00, 16'd300, 16'd400, 16'h0001, 16'hD4C0, 1'b0);

    // req_valid held across two requests.
    @(negedge clk);
    n_done = done_count;
    n_hs = hs_count;
    op = 2'b00; a = 16'd7; b = 16'd9; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'd10; b = 16'd11;
    t = 1; t_done1 = 0;
    while (t_done1 == 0 && t < 40) begin
      @(negedge clk); t++;
      if (done) t_done1 = t;
    end
    check_eq("held_first_latency", t_done1, 18);
    check_eq("held_first_lo", lo, 63);
    @(negedge clk);
    check_eq("held_ready_next", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("held_two_handshakes", hs_count - n_hs, 2);
    t = 1;
    while (!done && t < 40) begin
      @(negedge clk); t++;
    end
    check_eq("held_second_latency", t, 18);
    check_eq("held_second_lo", lo, 110);
    repeat (40) @(negedge clk);
    check_eq("held_done_pulses", done_count - n_done, 2);
    check_eq("held_handshakes_total", hs_count - n_hs, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
